// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: FSM encoding, default bus widths
// and a small index-width helper reused by the arbiter and the top block.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESP    = 2'd2,
        ILLEGAL = 2'd3
    } dmem_state_t;

    localparam int DMEM_DW = 16;
    localparam int DMEM_AW = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// rr_ptr (wrapping at N) and returns it as one-hot and binary index.
module dmem_rr_arbiter
    import dmem_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    logic [IW:0]   cand_sum [N];
    logic [IW-1:0] cand_idx [N];
    logic [N-1:0]  cand_oh  [N];
    logic [N-1:0]  hit;
    logic [N-1:0]  first;

    // Candidate gi is the core gi positions after rr_ptr; ptr < N so one wrap suffices.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            localparam logic [N-1:0] LOWER = (N'(1) << gi) - N'(1);
            assign cand_sum[gi] = {1'b0, rr_ptr} + (IW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (IW+1)'(N)) ?
                                  IW'(cand_sum[gi] - (IW+1)'(N)) : IW'(cand_sum[gi]);
            assign cand_oh[gi]  = N'(1) << cand_idx[gi];
            assign hit[gi]      = req[cand_idx[gi]];
            assign first[gi]    = hit[gi] & ~|(hit & LOWER);
        end
    endgenerate

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int j = 0; j < N; j++) begin
            if (first[j]) begin
                grant     = grant | cand_oh[j];
                grant_idx = grant_idx | cand_idx[j];
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shared data-memory responder: serves NCORES cores round-robin against one
// single-port RAM with a fixed IDLE -> ACCESS -> RESP sequence per access.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter  int NCORES     = 4,
    parameter  int DW         = DMEM_DW,
    parameter  int AW         = DMEM_AW,
    parameter  int DEPTH_LOG2 = 10,
    localparam int IW         = idx_width(NCORES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    mem_rd,
    input  logic [NCORES-1:0]    mem_wr,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [DW-1:0]        rdata,
    output logic [NCORES-1:0]    ack,
    output logic                 busy
);

    dmem_state_t           state_reg, state_next;
    logic [IW-1:0]         grant_reg;
    logic [NCORES-1:0]     grant_oh_reg;
    logic [IW-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [DEPTH_LOG2-1:0] addr_reg;
    logic [DW-1:0]         wdata_reg;
    logic [DW-1:0]         rdata_reg;
    logic                  is_wr_reg;

    logic [NCORES-1:0]     req;
    logic [NCORES-1:0]     arb_grant;
    logic [IW-1:0]         arb_idx;
    logic                  arb_valid;
    logic                  capture;
    logic                  ram_we;
    logic                  ram_re;

    logic [DEPTH_LOG2-1:0] addr_arr  [NCORES];
    logic [DW-1:0]         wdata_arr [NCORES];
    logic [DW-1:0]         mem       [2**DEPTH_LOG2];

    // Upper address bits are deliberately dropped so addresses alias modulo the RAM depth.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^addr;

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
            assign req[gi]       = mem_rd[gi] | mem_wr[gi];
            assign addr_arr[gi]  = addr[gi*AW +: DEPTH_LOG2];
            assign wdata_arr[gi] = wdata[gi*DW +: DW];
        end
    endgenerate

    dmem_rr_arbiter #(
        .N (NCORES)
    ) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        capture     = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    state_next = ACCESS;
                    capture    = 1'b1;
                end
            end
            ACCESS: begin
                state_next = RESP;
                ram_we     = is_wr_reg;
                ram_re     = ~is_wr_reg;
            end
            RESP: begin
                state_next  = IDLE;
                rr_ptr_next = (grant_reg == IW'(NCORES-1)) ? '0 : grant_reg + IW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            grant_oh_reg <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            is_wr_reg    <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            if (capture) begin
                grant_reg    <= arb_idx;
                grant_oh_reg <= arb_grant;
                addr_reg     <= addr_arr[arb_idx];
                wdata_reg    <= wdata_arr[arb_idx];
                is_wr_reg    <= mem_wr[arb_idx];
            end
            if (ram_re) begin
                rdata_reg <= mem[addr_reg];
            end
        end
    end

    // RAM contents survive reset; reset forces IDLE so a pending write never commits.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[addr_reg] <= wdata_reg;
        end
    end

    assign rdata = rdata_reg;
    assign busy  = (state_reg != IDLE);
    assign ack   = (state_reg == RESP) ? grant_oh_reg : '0;

endmodule
